// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : game_pkg                                                  |
// | Purpose  : Shared screen constants, ball kinematics types and the    |
// |            per-frame motion update state encoding.                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package game_pkg;

   localparam int C_SCREEN_W = 800;
   localparam int C_SCREEN_H = 600;

   // Ball centre coordinate on screen
   typedef logic [9:0] coord_t;
   // Signed per-frame velocity
   typedef logic signed [7:0] speed_t;
   // Width used for the position + velocity sum so it can go negative
   typedef logic signed [10:0] wide_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SAMPLE  = 3'd1,
      ST_ACCEL   = 3'd2,
      ST_DECEL   = 3'd3,
      ST_MOVE    = 3'd4,
      ST_COLLIDE = 3'd5,
      ST_DONE    = 3'd6
   } motion_state_e;

endpackage : game_pkg
`default_nettype wire

// File: rtl/axis_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axis_step                                                 |
// | Purpose  : Purely combinational kinematics for one screen axis:      |
// |            saturating acceleration, deceleration toward zero,        |
// |            position integration and wall clamp / bounce.             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module axis_step
   import game_pkg::*;
#(
   parameter int LIMIT     = 800,
   parameter int RADIUS    = 10,
   parameter int MAX_SPEED = 8
)(
   input  logic [9:0]  pos_i,        // committed ball position on this axis
   input  logic [7:0]  spd_i,        // working velocity for the current step
   input  logic [10:0] next_i,       // integrated position held from MOVE
   input  logic        btn_neg_i,    // latched button toward decreasing coordinate
   input  logic        btn_pos_i,    // latched button toward increasing coordinate
   input  logic        decel_en_i,   // frame counter has just wrapped
   output logic [7:0]  accel_spd_o,
   output logic [7:0]  decel_spd_o,
   output logic [10:0] next_o,
   output logic [9:0]  coll_pos_o,
   output logic [7:0]  coll_spd_o,
   output logic        bounce_o
);

   localparam speed_t C_MAX = speed_t'(MAX_SPEED);
   localparam speed_t C_MIN = -speed_t'(MAX_SPEED);
   localparam wide_t  C_LO  = wide_t'(RADIUS);
   localparam wide_t  C_HI  = wide_t'(LIMIT - 1 - RADIUS);

   speed_t w_spd;
   wide_t  w_next;
   speed_t w_accel;
   speed_t w_decel;

   assign w_spd  = speed_t'(spd_i);
   assign w_next = wide_t'(next_i);

   // Sign-extend the velocity and add it to the zero-extended position
   assign next_o = {1'b0, pos_i} + {{3{spd_i[7]}}, spd_i};

   // Accelerate only when exactly one direction is held; saturate symmetrically
   always_comb begin
      w_accel = w_spd;
      if (btn_pos_i && !btn_neg_i && (w_spd < C_MAX)) begin
         w_accel = w_spd + 8'sd1;
      end else if (btn_neg_i && !btn_pos_i && (w_spd > C_MIN)) begin
         w_accel = w_spd - 8'sd1;
      end
   end

   // Friction: one step toward zero on wrap frames, axis must be unpushed
   always_comb begin
      w_decel = w_spd;
      if (decel_en_i && !btn_neg_i && !btn_pos_i) begin
         if (w_spd > 8'sd0) begin
            w_decel = w_spd - 8'sd1;
         end else if (w_spd < 8'sd0) begin
            w_decel = w_spd + 8'sd1;
         end
      end
   end

   // Wall collision: clamp to the margin and reflect the velocity
   always_comb begin
      coll_pos_o = w_next[9:0];
      coll_spd_o = spd_i;
      bounce_o   = 1'b0;
      if (w_next < C_LO) begin
         coll_pos_o = C_LO[9:0];
         coll_spd_o = 8'(-w_spd);
         bounce_o   = 1'b1;
      end else if (w_next > C_HI) begin
         coll_pos_o = C_HI[9:0];
         coll_spd_o = 8'(-w_spd);
         bounce_o   = 1'b1;
      end
   end

   assign accel_spd_o = w_accel;
   assign decel_spd_o = w_decel;

endmodule : axis_step
`default_nettype wire

// File: rtl/ball_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ball_motion_ctrl                                          |
// | Purpose  : Per-frame ball update sequencer. Runs sample, accelerate, |
// |            decelerate, integrate and collide once per end_of_frame   |
// |            and publishes a position that is stable for the frame.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ball_motion_ctrl
   import game_pkg::*;
#(
   parameter int SCREEN_W     = C_SCREEN_W,
   parameter int SCREEN_H     = C_SCREEN_H,
   parameter int RADIUS       = 10,
   parameter int MAX_SPEED    = 8,
   parameter int DECEL_FRAMES = 5,
   parameter int START_X      = 400,
   parameter int START_Y      = 300
)(
   input  logic       pixel_clk,
   input  logic       rst,
   input  logic       end_of_frame,
   input  logic       button_c,
   input  logic       button_u,
   input  logic       button_d,
   input  logic       button_l,
   input  logic       button_r,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [7:0] speed_x,
   output logic [7:0] speed_y,
   output logic       busy,
   output logic       update_done,
   output logic       bounce_x,
   output logic       bounce_y,
   output logic       overrun
);

   localparam int             CNT_W      = (DECEL_FRAMES > 2) ? $clog2(DECEL_FRAMES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DECEL_FRAMES - 1);
   localparam coord_t         C_START_X  = coord_t'(START_X);
   localparam coord_t         C_START_Y  = coord_t'(START_Y);

   // Latched buttons: [4]=centre [3]=up [2]=down [1]=left [0]=right
   localparam int B_C = 4;
   localparam int B_U = 3;
   localparam int B_D = 2;
   localparam int B_L = 1;
   localparam int B_R = 0;

   motion_state_e    state_q;
   logic [CNT_W-1:0] frame_cnt_q;
   logic [4:0]       btn_q;
   logic [7:0]       wspd_x_q;
   logic [7:0]       wspd_y_q;
   logic [10:0]      next_x_q;
   logic [10:0]      next_y_q;
   coord_t           ball_x_q;
   coord_t           ball_y_q;
   logic [7:0]       speed_x_q;
   logic [7:0]       speed_y_q;
   logic             busy_q;
   logic             done_q;
   logic             bnc_x_q;
   logic             bnc_y_q;
   logic             overrun_q;

   logic             w_decel_en;
   logic [7:0]       w_x_accel;
   logic [7:0]       w_x_decel;
   logic [10:0]      w_x_next;
   logic [9:0]       w_x_pos;
   logic [7:0]       w_x_spd;
   logic             w_x_bnc;
   logic [7:0]       w_y_accel;
   logic [7:0]       w_y_decel;
   logic [10:0]      w_y_next;
   logic [9:0]       w_y_pos;
   logic [7:0]       w_y_spd;
   logic             w_y_bnc;

   // Counter was advanced in SAMPLE, so zero here means it has just wrapped
   assign w_decel_en = (frame_cnt_q == '0);

   axis_step #(
      .LIMIT     (SCREEN_W),
      .RADIUS    (RADIUS),
      .MAX_SPEED (MAX_SPEED)
   ) u_axis_x (
      .pos_i       (ball_x_q),
      .spd_i       (wspd_x_q),
      .next_i      (next_x_q),
      .btn_neg_i   (btn_q[B_L]),
      .btn_pos_i   (btn_q[B_R]),
      .decel_en_i  (w_decel_en),
      .accel_spd_o (w_x_accel),
      .decel_spd_o (w_x_decel),
      .next_o      (w_x_next),
      .coll_pos_o  (w_x_pos),
      .coll_spd_o  (w_x_spd),
      .bounce_o    (w_x_bnc)
   );

   axis_step #(
      .LIMIT     (SCREEN_H),
      .RADIUS    (RADIUS),
      .MAX_SPEED (MAX_SPEED)
   ) u_axis_y (
      .pos_i       (ball_y_q),
      .spd_i       (wspd_y_q),
      .next_i      (next_y_q),
      .btn_neg_i   (btn_q[B_U]),
      .btn_pos_i   (btn_q[B_D]),
      .decel_en_i  (w_decel_en),
      .accel_spd_o (w_y_accel),
      .decel_spd_o (w_y_decel),
      .next_o      (w_y_next),
      .coll_pos_o  (w_y_pos),
      .coll_spd_o  (w_y_spd),
      .bounce_o    (w_y_bnc)
   );

   // Update sequencer; published outputs change only on entry to DONE
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         btn_q       <= '0;
         wspd_x_q    <= '0;
         wspd_y_q    <= '0;
         next_x_q    <= '0;
         next_y_q    <= '0;
         ball_x_q    <= C_START_X;
         ball_y_q    <= C_START_Y;
         speed_x_q   <= '0;
         speed_y_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         bnc_x_q     <= 1'b0;
         bnc_y_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         // A frame boundary while an update is still in flight is lost
         if (end_of_frame && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (end_of_frame) begin
                  state_q <= ST_SAMPLE;
                  busy_q  <= 1'b1;
               end
            end
            ST_SAMPLE: begin
               btn_q    <= {button_c, button_u, button_d, button_l, button_r};
               wspd_x_q <= speed_x_q;
               wspd_y_q <= speed_y_q;
               // Recentre frames leave the friction cadence untouched
               if (!button_c) begin
                  frame_cnt_q <= (frame_cnt_q == C_CNT_LAST) ? '0 : frame_cnt_q + 1'b1;
               end
               state_q <= ST_ACCEL;
            end
            ST_ACCEL: begin
               // Recentre acts on the latched copy, hence one cycle after SAMPLE
               if (btn_q[B_C]) begin
                  ball_x_q  <= C_START_X;
                  ball_y_q  <= C_START_Y;
                  speed_x_q <= '0;
                  speed_y_q <= '0;
                  bnc_x_q   <= 1'b0;
                  bnc_y_q   <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
               end else begin
                  wspd_x_q <= w_x_accel;
                  wspd_y_q <= w_y_accel;
                  state_q  <= ST_DECEL;
               end
            end
            ST_DECEL: begin
               wspd_x_q <= w_x_decel;
               wspd_y_q <= w_y_decel;
               state_q  <= ST_MOVE;
            end
            ST_MOVE: begin
               next_x_q <= w_x_next;
               next_y_q <= w_y_next;
               state_q  <= ST_COLLIDE;
            end
            ST_COLLIDE: begin
               ball_x_q  <= w_x_pos;
               ball_y_q  <= w_y_pos;
               speed_x_q <= w_x_spd;
               speed_y_q <= w_y_spd;
               bnc_x_q   <= w_x_bnc;
               bnc_y_q   <= w_y_bnc;
               done_q    <= 1'b1;
               state_q   <= ST_DONE;
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               bnc_x_q <= 1'b0;
               bnc_y_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               bnc_x_q <= 1'b0;
               bnc_y_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ball_x      = ball_x_q;
   assign ball_y      = ball_y_q;
   assign speed_x     = speed_x_q;
   assign speed_y     = speed_y_q;
   assign busy        = busy_q;
   assign update_done = done_q;
   assign bounce_x    = bnc_x_q;
   assign bounce_y    = bnc_y_q;
   assign overrun     = overrun_q;

endmodule : ball_motion_ctrl
`default_nettype wire

// File: tb/tb_ball_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ball_motion_ctrl                                       |
// | Purpose  : Directed self-checking bench for ball_motion_ctrl.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ball_motion_ctrl;

   // Button vectors, order {c, u, d, l, r}
   localparam logic [4:0] B_NONE = 5'b00000;
   localparam logic [4:0] B_R    = 5'b00001;
   localparam logic [4:0] B_U    = 5'b01000;
   localparam logic [4:0] B_CR   = 5'b10001;

   logic       pixel_clk;
   logic       rst;
   logic       end_of_frame;
   logic       button_c, button_u, button_d, button_l, button_r;
   logic [9:0] ball_x, ball_y;
   logic [7:0] speed_x, speed_y;
   logic       busy, update_done, bounce_x, bounce_y, overrun;

   int   n_checks = 0;
   int   n_errors = 0;
   logic bx_seen, by_seen;

   // Decel scenario: R held for frames 1..3, released afterwards
   int t3_sx[20] = '{1,2,3,3,2,2,2,2,2,1,1,1,1,1,0,0,0,0,0,0};
   int t3_x [20] = '{401,403,406,409,411,413,415,417,419,420,
                     421,422,423,424,424,424,424,424,424,424};
   int t2_sx[10] = '{1,2,3,4,5,6,7,8,8,8};

   ball_motion_ctrl dut (
      .pixel_clk    (pixel_clk),
      .rst          (rst),
      .end_of_frame (end_of_frame),
      .button_c     (button_c),
      .button_u     (button_u),
      .button_d     (button_d),
      .button_l     (button_l),
      .button_r     (button_r),
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .speed_x      (speed_x),
      .speed_y      (speed_y),
      .busy         (busy),
      .update_done  (update_done),
      .bounce_x     (bounce_x),
      .bounce_y     (bounce_y),
      .overrun      (overrun)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic do_reset();
      end_of_frame = 1'b0;
      {button_c, button_u, button_d, button_l, button_r} = B_NONE;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // One full frame update; checks latency and busy width, records bounces
   task automatic frame(input logic [4:0] btn, input int exp_lat);
      int  lat;
      int  busy_cnt;
      bit  seen;
      lat      = 0;
      busy_cnt = 0;
      seen     = 0;
      {button_c, button_u, button_d, button_l, button_r} = btn;
      end_of_frame = 1'b1;
      step();
      end_of_frame = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (!seen) begin
            if (busy) busy_cnt++;
            if (update_done) begin
               seen    = 1;
               lat     = k;
               bx_seen = bounce_x;
               by_seen = bounce_y;
            end else begin
               step();
            end
         end
      end
      check("latency", lat, exp_lat);
      check("busy_cycles", busy_cnt, exp_lat);
      step();
      check("busy_idle", busy, 0);
   endtask

   initial begin
      int cnt;
      rst          = 1'b1;
      end_of_frame = 1'b0;
      {button_c, button_u, button_d, button_l, button_r} = B_NONE;
      bx_seen = 1'b0;
      by_seen = 1'b0;
      #1;
      check("rst_ball_x", ball_x, 400);
      check("rst_ball_y", ball_y, 300);
      check("rst_speed_x", $signed(speed_x), 0);
      check("rst_speed_y", $signed(speed_y), 0);
      check("rst_busy", busy, 0);
      check("rst_done", update_done, 0);
      check("rst_overrun", overrun, 0);
      step();
      step();
      rst = 1'b0;

      // Idle frame: nothing moves
      frame(B_NONE, 6);
      check("idle_x", ball_x, 400);
      check("idle_y", ball_y, 300);
      check("idle_sx", $signed(speed_x), 0);
      check("idle_bx", bx_seen, 0);

      // Right held: speed saturates at 8
      do_reset();
      for (int f = 0; f < 10; f++) begin
         frame(B_R, 6);
         check("accel_sx", $signed(speed_x), t2_sx[f]);
      end
      check("accel_x", ball_x, 452);
      check("accel_y", ball_y, 300);

      // Friction only on counter-wrap frames, no undershoot
      do_reset();
      for (int f = 0; f < 20; f++) begin
         frame((f < 3) ? B_R : B_NONE, 6);
         check("decel_sx", $signed(speed_x), t3_sx[f]);
         check("decel_x", ball_x, t3_x[f]);
      end

      // Right wall
      do_reset();
      for (int f = 0; f < 52; f++) frame(B_R, 6);
      check("wall_pre_x", ball_x, 788);
      check("wall_pre_sx", $signed(speed_x), 8);
      check("wall_pre_bx", bx_seen, 0);
      frame(B_R, 6);
      check("wall_x", ball_x, 789);
      check("wall_sx", $signed(speed_x), -8);
      check("wall_bx", bx_seen, 1);
      check("wall_by", by_seen, 0);
      frame(B_NONE, 6);
      check("after_wall_x", ball_x, 781);
      check("after_wall_sx", $signed(speed_x), -8);
      frame(B_NONE, 6);
      check("neg_decel_x", ball_x, 774);
      check("neg_decel_sx", $signed(speed_x), -7);

      // Recentre, then show the friction cadence did not move
      frame(B_CR, 3);
      check("ctr_x", ball_x, 400);
      check("ctr_y", ball_y, 300);
      check("ctr_sx", $signed(speed_x), 0);
      check("ctr_sy", $signed(speed_y), 0);
      frame(B_R, 6);
      frame(B_NONE, 6);
      frame(B_NONE, 6);
      frame(B_NONE, 6);
      check("ctr_cnt_sx", $signed(speed_x), 1);
      check("ctr_cnt_x", ball_x, 404);
      frame(B_NONE, 6);
      check("ctr_wrap_sx", $signed(speed_x), 0);
      check("ctr_wrap_x", ball_x, 404);

      // Top wall
      do_reset();
      for (int f = 0; f < 39; f++) frame(B_U, 6);
      check("top_pre_y", ball_y, 16);
      check("top_pre_sy", $signed(speed_y), -8);
      frame(B_U, 6);
      check("top_y", ball_y, 10);
      check("top_sy", $signed(speed_y), 8);
      check("top_by", by_seen, 1);
      check("top_bx", bx_seen, 0);
      check("top_x", ball_x, 400);

      // end_of_frame coincident with DONE
      do_reset();
      end_of_frame = 1'b1;
      step();
      end_of_frame = 1'b0;
      repeat (5) step();
      check("done_cyc6", update_done, 1);
      end_of_frame = 1'b1;
      step();
      end_of_frame = 1'b0;
      check("ovr_done", overrun, 1);
      step();
      check("ovr_done_norestart", busy, 0);

      // Second end_of_frame three cycles in
      do_reset();
      check("ovr_clear", overrun, 0);
      end_of_frame = 1'b1;
      step();
      end_of_frame = 1'b0;
      step();
      step();
      end_of_frame = 1'b1;
      step();
      end_of_frame = 1'b0;
      check("ovr_set", overrun, 1);
      step();
      check("ovr_no_early_done", update_done, 0);
      step();
      check("ovr_done6", update_done, 1);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (update_done) cnt++;
      end
      check("ovr_no_restart", cnt, 0);
      check("ovr_sticky", overrun, 1);

      // Asynchronous reset in the middle of MOVE
      do_reset();
      frame(B_R, 6);
      frame(B_R, 6);
      check("pre_rst_x", ball_x, 403);
      end_of_frame = 1'b1;
      step();
      end_of_frame = 1'b0;
      repeat (3) step();
      #2;
      rst = 1'b1;
      #1;
      check("async_x", ball_x, 400);
      check("async_sx", $signed(speed_x), 0);
      check("async_busy", busy, 0);
      @(negedge pixel_clk);
      @(negedge pixel_clk);
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (update_done) cnt++;
      end
      check("async_no_done", cnt, 0);
      check("async_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_ball_motion_ctrl
`default_nettype wire

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Per-frame sequencer for the ball kinematics datapath in the VGA game.
- On each end-of-frame pulse it runs a fixed multi-cycle update: sample buttons, accelerate, decelerate, integrate position, collide with screen edges.
- Publishes the new ball position and speed to the pixel renderer, which stays stable for the whole active frame.
- Replaces the ad-hoc single-cycle update with a controlled, saturating, wall-bouncing schedule.

Parameters:
- SCREEN_W, 800, active width in pixels.
- SCREEN_H, 600, active height in pixels.
- RADIUS, 10, ball radius in pixels; sets the collision margin.
- MAX_SPEED, 8, speed magnitude saturation limit, in pixels per frame.
- DECEL_FRAMES, 5, frames between deceleration steps.
- START_X, 400, reset/recentre x.
- START_Y, 300, reset/recentre y.

Ports:
- pixel_clk  in  1  pixel clock (36 MHz), the only clock.
- rst  in  1  asynchronous, active-high reset.
- end_of_frame  in  1  single-cycle pulse at the end of the active frame.
- button_c  in  1  recentre request; level, already synchronised.
- button_u  in  1  accelerate up (−y); level.
- button_d  in  1  accelerate down (+y); level.
- button_l  in  1  accelerate left (−x); level.
- button_r  in  1  accelerate right (+x); level.
- ball_x  out  10  ball centre x.
- ball_y  out  10  ball centre y.
- speed_x  out  8  signed x velocity.
- speed_y  out  8  signed y velocity.
- busy  out  1  high while the update FSM is not IDLE.
- update_done  out  1  one-cycle pulse when the new position is committed.
- bounce_x  out  1  one-cycle pulse, concurrent with update_done, if an x wall was hit this update.
- bounce_y  out  1  one-cycle pulse, concurrent with update_done, if a y wall was hit this update.
- overrun  out  1  sticky; set if end_of_frame arrives while busy; cleared only by rst.

Behaviour:
- Reset values (asynchronous, immediate, also mid-update):
  - ball_x = START_X, ball_y = START_Y, speed_x = speed_y = 0.
  - busy, update_done, bounce_x, bounce_y, overrun all 0.
  - Frame counter = 0; FSM = IDLE.
- FSM states: IDLE, SAMPLE, ACCEL, DECEL, MOVE, COLLIDE, DONE. Each non-IDLE state lasts exactly 1 cycle.
  - IDLE -> SAMPLE on end_of_frame.
  - SAMPLE -> ACCEL normally. If button_c is high: load the START position, zero both speeds, go directly to DONE.
  - ACCEL -> DECEL -> MOVE -> COLLIDE -> DONE -> IDLE.
- Latency: update_done is asserted exactly 6 cycles after the end_of_frame cycle (3 cycles on the recentre path). busy is high from SAMPLE through DONE inclusive.
- SAMPLE: latch all five buttons. Later states use only the latched copies.
- Frame counter: in SAMPLE it advances 0..DECEL_FRAMES-1 and wraps to 0. It does not advance on the recentre path.
- ACCEL, per axis:
  - Exactly one direction button pressed: speed ±1 toward that direction, saturating at ±MAX_SPEED.
  - Both or neither pressed: no change.
- DECEL:
  - Only when the counter has just wrapped to 0, and only on an axis with no direction button latched.
  - The nonzero speed magnitude drops by 1 toward 0 and never crosses 0.
- MOVE: next = position + sign-extended speed, computed in 11-bit signed. Results are held internally; the outputs are not updated yet.
- COLLIDE, per axis:
  - next < RADIUS: position = RADIUS, speed negated, bounce flag set.
  - next > LIMIT−1−RADIUS (LIMIT = SCREEN_W or SCREEN_H): clamp to that value, negate speed, set bounce flag.
  - Otherwise position = next.
  - Negation of ±MAX_SPEED stays in range because saturation is symmetric.
- DONE: ball_x, ball_y, speed_x and speed_y are committed in this cycle and are otherwise held constant. Pulse update_done and the bounce flags.
- end_of_frame while busy: ignored, no restart; overrun is set.
- end_of_frame coincident with the DONE cycle counts as overrun.

Decomposition:
- game_pkg holds:
  - Screen constants (800, 600).
  - The coord_t (10-bit) and speed_t (signed 8-bit) typedefs.
  - The motion_state_e enum.
- Sub-module axis_step covers one axis: accel/saturate, decel, integrate, clamp/bounce as pure combinational functions of the state-select inputs. It is instantiated twice, for x with LIMIT = SCREEN_W and for y with LIMIT = SCREEN_H.

Test Plan:
- Reset, then one end_of_frame with no buttons -> update_done 6 cycles later; ball (400,300), speeds 0; busy high for exactly 6 cycles.
- button_r held for 10 frames -> speed_x 1,2,…,8,8,8 (saturates); ball_x accumulates to 400+1+2+…+8+8+8 = 452.
- speed_x=3, no buttons, frames 1..10 -> speed_x decrements only on counter-wrap frames (3→2→1) and stops at 0 with no undershoot.
- ball_x=785, speed_x=+8 -> ball_x=789, speed_x=−8, bounce_x pulse concurrent with update_done. Symmetric case: ball_y=12, speed_y=−5 -> ball_y=10, speed_y=+5, bounce_y.
- button_c with ball (600,100), speeds (4,−3) -> after 3 cycles ball (400,300), speeds 0; frame counter unchanged.
- Second end_of_frame 3 cycles after the first -> ignored, overrun=1 and stays set. rst asserted mid-update (MOVE) -> all outputs return to reset values asynchronously, with no update_done.
